// File: rtl/stepper_drv_seq.sv
// Unipolar stepper sequencer: command-driven wave/full/half-step moves with abort,
// a signed position counter and a prescaled tick enable for step timing.
module stepper_drv_seq #(
    parameter int PRESC_W   = 12,
    parameter int PERIOD_W  = 16,
    parameter int COUNT_W   = 16,
    parameter int POS_W     = 24,
    parameter int IDLE_HOLD = 1
) (
    input  logic                CLK,
    input  logic                rstn,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic                cmd_dir,
    input  logic [1:0]          cmd_mode,
    input  logic [COUNT_W-1:0]  cmd_steps,
    input  logic [PERIOD_W-1:0] cmd_period,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic [POS_W-1:0]    position,
    output logic                A1,
    output logic                B1,
    output logic                A2,
    output logic                B2
);

    // state   | meaning
    // IDLE    | waiting for a command, cmd_ready high
    // RUN     | issuing steps on tick/period boundaries
    // FIN     | one-cycle done pulse, then back to IDLE
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_FIN  = 2'd2;

    logic [1:0]          state_q,     state_d;
    logic [2:0]          idx_q,       idx_d;
    logic [PRESC_W-1:0]  presc_q,     presc_d;
    logic [PERIOD_W-1:0] timer_q,     timer_d;
    logic [PERIOD_W-1:0] period_q,    period_d;
    logic [COUNT_W-1:0]  remaining_q, remaining_d;
    logic                dir_q,       dir_d;
    logic                half_q,      half_d;
    logic [POS_W-1:0]    pos_q,       pos_d;
    logic                aborted_q,   aborted_d;
    logic [3:0]          coils_q,     coils_d;

    logic                tick;
    logic [2:0]          stride;
    logic [PERIOD_W-1:0] timer_inc;

    // coil vector order is {B2, A2, B1, A1}
    function automatic logic [3:0] phase_coils(input logic [2:0] idx);
        logic [3:0] c;
        case (idx)
            3'd0:    c = 4'b0001;
            3'd1:    c = 4'b0011;
            3'd2:    c = 4'b0010;
            3'd3:    c = 4'b0110;
            3'd4:    c = 4'b0100;
            3'd5:    c = 4'b1100;
            3'd6:    c = 4'b1000;
            default: c = 4'b1001;
        endcase
        return c;
    endfunction

    assign tick      = &presc_q;
    assign stride    = half_q ? 3'd1 : 3'd2;
    assign timer_inc = timer_q + PERIOD_W'(1);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        presc_d     = presc_q + PRESC_W'(1);
        timer_d     = timer_q;
        period_d    = period_q;
        remaining_d = remaining_q;
        dir_d       = dir_q;
        half_d      = half_q;
        pos_d       = pos_q;
        aborted_d   = aborted_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    dir_d       = cmd_dir;
                    half_d      = (cmd_mode == 2'd2);
                    period_d    = (cmd_period == '0) ? PERIOD_W'(1) : cmd_period;
                    remaining_d = cmd_steps;
                    aborted_d   = 1'b0;
                    presc_d     = '0;
                    timer_d     = '0;
                    // alignment puts wave on even phases and full on odd phases
                    case (cmd_mode)
                        2'd0:    idx_d = {idx_q[2:1], 1'b0};
                        2'd2:    idx_d = idx_q;
                        default: idx_d = {idx_q[2:1], 1'b1};
                    endcase
                    state_d = (cmd_steps == '0) ? ST_FIN : ST_RUN;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    state_d   = ST_FIN;
                end else if (tick) begin
                    if (timer_inc == period_q) begin
                        timer_d     = '0;
                        idx_d       = dir_q ? (idx_q + stride) : (idx_q - stride);
                        pos_d       = dir_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));
                        remaining_d = remaining_q - COUNT_W'(1);
                        if (remaining_q == COUNT_W'(1)) begin
                            state_d = ST_FIN;
                        end
                    end else begin
                        timer_d = timer_inc;
                    end
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // coils follow the next index so a step is visible on the same edge it is taken
        if ((state_d == ST_IDLE) && (IDLE_HOLD == 0)) begin
            coils_d = 4'b0000;
        end else begin
            coils_d = phase_coils(idx_d);
        end
    end

    always_ff @(posedge CLK) begin
        if (!rstn) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            presc_q     <= '0;
            timer_q     <= '0;
            period_q    <= PERIOD_W'(1);
            remaining_q <= '0;
            dir_q       <= 1'b0;
            half_q      <= 1'b0;
            pos_q       <= '0;
            aborted_q   <= 1'b0;
            coils_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            presc_q     <= presc_d;
            timer_q     <= timer_d;
            period_q    <= period_d;
            remaining_q <= remaining_d;
            dir_q       <= dir_d;
            half_q      <= half_d;
            pos_q       <= pos_d;
            aborted_q   <= aborted_d;
            coils_q     <= coils_d;
        end
    end

    assign cmd_ready = rstn && (state_q == ST_IDLE);
    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_FIN);
    assign aborted   = aborted_q;
    assign position  = pos_q;
    assign A1        = coils_q[0];
    assign B1        = coils_q[1];
    assign A2        = coils_q[2];
    assign B2        = coils_q[3];

endmodule
